// File: rtl/link_regfile.sv
// link_regfile: architectural register file with jump-and-link writeback,
// same-cycle read bypass and a circular return-address stack (RAS).
// The writeback port and the link port may both write in one cycle; the
// link value wins on an address collision. Register 0 is hard-wired to zero.
module link_regfile #(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int RAS_DEPTH   = 4,
    parameter int LINK_OFFSET = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_we_i,
    input  logic [$clog2(NREG)-1:0]      wb_addr_i,
    input  logic [XLEN-1:0]              wb_data_i,
    input  logic                         jal_i,
    input  logic [$clog2(NREG)-1:0]      jal_rd_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic                         ret_i,
    input  logic [$clog2(NREG)-1:0]      rs1_addr_i,
    input  logic [$clog2(NREG)-1:0]      rs2_addr_i,
    output logic [XLEN-1:0]              rs1_data_o,
    output logic [XLEN-1:0]              rs2_data_o,
    output logic [XLEN-1:0]              ras_top_o,
    output logic                         ras_valid_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

    localparam int AW = $clog2(NREG);
    localparam int RW = $clog2(RAS_DEPTH);
    localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] ras  [RAS_DEPTH];
    logic [RW-1:0]   ras_ptr;
    logic [RW-1:0]   ras_ptr_inc;
    logic [RW-1:0]   ras_ptr_dec;
    logic [RW:0]     ras_cnt;

    logic [XLEN-1:0] link_val;
    logic            link_we;
    logic            wb_we;
    logic            push;
    logic            pop;

    // Link value wraps naturally at XLEN bits.
    assign link_val = pc_i + XLEN'(LINK_OFFSET);

    // Writes are qualified by a non-zero destination and dropped during reset.
    assign link_we = jal_i   && (jal_rd_i  != '0) && !rst_i;
    assign wb_we   = wb_we_i && (wb_addr_i != '0) && !rst_i;

    // Only the conventional link registers (x1, x5) push a return address.
    // The comparison is done at 32 bits so small NREG cannot alias 5 onto 1.
    assign push = jal_i && ((32'(jal_rd_i) == 32'd1) || (32'(jal_rd_i) == 32'd5));
    assign pop  = ret_i && (ras_cnt != '0);

    assign ras_ptr_inc = ras_ptr + RW'(1);
    assign ras_ptr_dec = ras_ptr - RW'(1);

    // Read port with bypass: link write first, then writeback, then storage.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        d = regs[a];
        if (a == '0) begin
            d = '0;
        end else if (link_we && (jal_rd_i == a)) begin
            d = link_val;
        end else if (wb_we && (wb_addr_i == a)) begin
            d = wb_data_i;
        end
        return d;
    endfunction

    assign rs1_data_o = read_port(rs1_addr_i);
    assign rs2_data_o = read_port(rs2_addr_i);

    // Register file update; the link write is last so it wins a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_we) begin
                regs[wb_addr_i] <= wb_data_i;
            end
            if (link_we) begin
                regs[jal_rd_i] <= link_val;
            end
        end
    end

    // Return-address stack: ras_ptr addresses the current top entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (push && pop) begin
            // Call replacing a return: overwrite top in place.
            ras[ras_ptr] <= link_val;
        end else if (push) begin
            // When full, advancing the pointer overwrites the oldest entry.
            ras[ras_ptr_inc] <= link_val;
            ras_ptr          <= ras_ptr_inc;
            if (ras_cnt != RAS_FULL) begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (pop) begin
            ras_ptr <= ras_ptr_dec;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    assign ras_valid_o = (ras_cnt != '0);
    assign ras_top_o   = ras_valid_o ? ras[ras_ptr] : '0;
    assign ras_count_o = ras_cnt;

endmodule

// File: tb/tb_link_regfile.sv
// Directed bench for link_regfile. Each table row is applied just after a
// rising edge; combinational reads (with bypass) and registered RAS outputs
// are compared on the following falling edge, then the clock advances.
module tb_link_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        jal_i;
    logic [4:0]  jal_rd_i;
    logic [31:0] pc_i;
    logic        ret_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] ras_top_o;
    logic        ras_valid_o;
    logic [2:0]  ras_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    link_regfile dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .jal_i       (jal_i),
        .jal_rd_i    (jal_rd_i),
        .pc_i        (pc_i),
        .ret_i       (ret_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .ras_top_o   (ras_top_o),
        .ras_valid_o (ras_valid_o),
        .ras_count_o (ras_count_o)
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        jal;
        logic [4:0]  jal_rd;
        logic [31:0] pc;
        logic        ret;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_top;
        logic        e_valid;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic wb_we, input logic [4:0] wb_addr, input logic [31:0] wb_data,
        input logic jal, input logic [4:0] jal_rd, input logic [31:0] pc,
        input logic ret, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [31:0] e_rs1, input logic [31:0] e_rs2,
        input logic [31:0] e_top, input logic e_valid, input logic [2:0] e_cnt);
        vec_t v;
        v.wb_we = wb_we; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.jal = jal; v.jal_rd = jal_rd; v.pc = pc; v.ret = ret;
        v.rs1 = rs1; v.rs2 = rs2; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
        v.e_top = e_top; v.e_valid = e_valid; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        jal_i = 1'b0; jal_rd_i = '0; pc_i = '0; ret_i = 1'b0;
        rs1_addr_i = '0; rs2_addr_i = '0;
    endtask

    task automatic apply(input vec_t v);
        wb_we_i = v.wb_we; wb_addr_i = v.wb_addr; wb_data_i = v.wb_data;
        jal_i = v.jal; jal_rd_i = v.jal_rd; pc_i = v.pc; ret_i = v.ret;
        rs1_addr_i = v.rs1; rs2_addr_i = v.rs2;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //              we adr wdata         jal rd  pc            ret rs1 rs2  e_rs1         e_rs2         e_top        v  cnt
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  5,  32'h0,        32'h0,        32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h100,      0,  1,  0,  32'h104,      32'h0,        32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  1,  2,  32'h104,      32'h0,        32'h104,     1, 1));
        vecs.push_back(mk(1, 3, 32'hAAAA,     1, 3,  32'h200,      0,  3,  1,  32'h204,      32'h104,      32'h104,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  3,  0,  32'h204,      32'h0,        32'h104,     1, 1));
        vecs.push_back(mk(1, 0, 32'hFFFF,     0, 0,  32'h0,        0,  0,  3,  32'h0,        32'h204,      32'h104,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  3,  32'h0,        32'h204,      32'h104,     1, 1));
        vecs.push_back(mk(1, 7, 32'h1234,     1, 9,  32'h500,      0,  7,  9,  32'h1234,     32'h504,      32'h104,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  7,  9,  32'h1234,     32'h504,      32'h104,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 5,  32'h300,      1,  5,  7,  32'h304,      32'h1234,     32'h104,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  5,  1,  32'h304,      32'h104,      32'h304,     1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  0,  32'h104,      32'h0,        32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  1,  5,  32'h104,      32'h304,      32'h0,       0, 0));
        // Five pushes into a four-deep stack, then five pops.
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h10,       0,  1,  0,  32'h14,       32'h0,        32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h20,       0,  1,  0,  32'h24,       32'h0,        32'h14,      1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h30,       0,  1,  0,  32'h34,       32'h0,        32'h24,      1, 2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h40,       0,  1,  0,  32'h44,       32'h0,        32'h34,      1, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1,  32'h50,       0,  1,  0,  32'h54,       32'h0,        32'h44,      1, 4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  3,  32'h54,       32'h204,      32'h54,      1, 4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  3,  32'h54,       32'h204,      32'h44,      1, 3));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  3,  32'h54,       32'h204,      32'h34,      1, 2));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  3,  32'h54,       32'h204,      32'h24,      1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1,  1,  3,  32'h54,       32'h204,      32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  1,  3,  32'h54,       32'h204,      32'h0,       0, 0));
        // Link value wraps modulo 2^32; rd=2 does not push.
        vecs.push_back(mk(0, 0, 32'h0,        1, 2,  32'hFFFF_FFFE, 0, 2,  1,  32'h2,        32'h54,       32'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  2,  1,  32'h2,        32'h54,       32'h0,       0, 0));

        // Reset, then every register reads zero and the RAS is empty.
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr_i = 5'(a);
            rs2_addr_i = 5'(31 - a);
            #1;
            chk($sformatf("reset_rs1[%0d]", a), rs1_data_o, 32'h0);
            chk($sformatf("reset_rs2[%0d]", 31 - a), rs2_data_o, 32'h0);
        end
        chk("reset_top", ras_top_o, 32'h0);
        chk("reset_valid", 32'(ras_valid_o), 32'h0);
        chk("reset_count", 32'(ras_count_o), 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk_i);
            chk($sformatf("v%0d_rs1", i), rs1_data_o, vecs[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), rs2_data_o, vecs[i].e_rs2);
            chk($sformatf("v%0d_top", i), ras_top_o, vecs[i].e_top);
            chk($sformatf("v%0d_valid", i), 32'(ras_valid_o), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_count", i), 32'(ras_count_o), 32'(vecs[i].e_cnt));
            next_cycle();
        end

        // Reset wins over a concurrent link write, writeback, push and pop.
        idle_inputs();
        jal_i = 1'b1; jal_rd_i = 5'd1; pc_i = 32'h700;
        next_cycle();
        idle_inputs();
        rs1_addr_i = 5'd7;
        #1;
        chk("pre_rst_reg7", rs1_data_o, 32'h1234);
        chk("pre_rst_count", 32'(ras_count_o), 32'h1);
        chk("pre_rst_top", ras_top_o, 32'h704);
        rst_i = 1'b1;
        jal_i = 1'b1; jal_rd_i = 5'd7; pc_i = 32'h800;
        wb_we_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'hBEEF;
        ret_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        idle_inputs();
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd8;
        #1;
        chk("post_rst_reg7", rs1_data_o, 32'h0);
        chk("post_rst_reg8", rs2_data_o, 32'h0);
        chk("post_rst_count", 32'(ras_count_o), 32'h0);
        chk("post_rst_valid", 32'(ras_valid_o), 32'h0);
        chk("post_rst_top", ras_top_o, 32'h0);

        // Push via x5 after reset, pop it, then a pop on empty changes nothing.
        jal_i = 1'b1; jal_rd_i = 5'd5; pc_i = 32'hA00;
        next_cycle();
        idle_inputs();
        #1;
        chk("x5_push_top", ras_top_o, 32'hA04);
        chk("x5_push_count", 32'(ras_count_o), 32'h1);
        ret_i = 1'b1;
        next_cycle();
        next_cycle();
        ret_i = 1'b0;
        #1;
        chk("empty_pop_count", 32'(ras_count_o), 32'h0);
        chk("empty_pop_valid", 32'(ras_valid_o), 32'h0);
        // A fresh push after the ignored pop lands as the single live entry.
        jal_i = 1'b1; jal_rd_i = 5'd1; pc_i = 32'hB00;
        next_cycle();
        idle_inputs();
        #1;
        chk("repush_top", ras_top_o, 32'hB04);
        chk("repush_count", 32'(ras_count_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/link_regfile.md
LINK_REGFILE -- requirements
Module: link_regfile

Interface
REQ-001 Parameter XLEN, default 32, data and PC width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of 2, >=2).
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-004 Parameter LINK_OFFSET, default 4, added to pc_i to form link value.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 wb_we_i  in  1  writeback write enable.
REQ-008 wb_addr_i  in  log2(NREG)  writeback destination.
REQ-009 wb_data_i  in  XLEN  writeback data.
REQ-010 jal_i  in  1  jump-and-link write enable.
REQ-011 jal_rd_i  in  log2(NREG)  link destination.
REQ-012 pc_i  in  XLEN  PC of jump instruction.
REQ-013 ret_i  in  1  return pops RAS.
REQ-014 rs1_addr_i, rs2_addr_i  in  log2(NREG)  read addresses.
REQ-015 rs1_data_o, rs2_data_o  out  XLEN  read data, combinational.
REQ-016 ras_top_o  out  XLEN  predicted return address.
REQ-017 ras_valid_o  out  1  RAS non-empty.
REQ-018 ras_count_o  out  log2(RAS_DEPTH)+1  RAS occupancy.

Function
REQ-019 Link value SHALL be (pc_i + LINK_OFFSET) mod 2^XLEN.
REQ-020 Register 0 SHALL never be written and SHALL always read 0.
REQ-021 jal_i=1 and jal_rd_i!=0 SHALL write link value to reg[jal_rd_i] at next edge.
REQ-022 wb_we_i=1 and wb_addr_i!=0 SHALL write wb_data_i to reg[wb_addr_i] at next edge.
REQ-023 Both writes, different addresses: both SHALL commit same edge; same address: link value wins.
REQ-024 Read port SHALL bypass: address !=0 matching an active write this cycle returns that write's data (link priority per REQ-023), else stored value.
REQ-025 Push SHALL occur when jal_i=1 and jal_rd_i is 1 or 5; pushed value is link value.
REQ-026 Pop SHALL occur when ret_i=1 and count>0; ret_i with count=0 SHALL be ignored.
REQ-027 RAS SHALL be circular: top pointer increments mod RAS_DEPTH on push, decrements on pop.
REQ-028 Push when count=RAS_DEPTH SHALL overwrite oldest entry; count stays RAS_DEPTH.
REQ-029 Push and pop same cycle, count>0: top entry replaced by link value, pointer and count unchanged; count=0: push only.
REQ-030 ras_top_o SHALL equal top entry when count>0, else 0; ras_valid_o = (count>0); both reflect registered state (one-cycle latency after push/pop).
REQ-031 Writes with rst_i=1 SHALL be discarded.

Reset
REQ-032 rst_i=1 at an edge SHALL clear all registers, all RAS entries, pointer and count to 0; rs*_data_o read 0, ras_top_o=0, ras_valid_o=0, ras_count_o=0 next cycle.
REQ-033 Reset mid-operation SHALL take priority over any concurrent write, push or pop.

Verification
REQ-034 jal_i=1, jal_rd_i=1, pc_i=0x100 -> reg1=0x104, ras_top_o=0x104, ras_count_o=1 next cycle.
REQ-035 wb_we_i=1 and jal_i=1 both to addr 3, wb_data_i=0xAAAA, pc_i=0x200 -> rs1_addr_i=3 reads 0x204 same cycle (bypass) and after edge.
REQ-036 wb_we_i=1, wb_addr_i=0, wb_data_i=0xFFFF -> rs1_addr_i=0 reads 0 same and next cycle.
REQ-037 Five pushes pc_i=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> count=4; four pops return 0x54,0x44,0x34,0x24; fifth pop ignored, ras_valid_o=0.
REQ-038 Push 0x100 then push+pop with pc_i=0x300 -> ras_top_o=0x304, count=1; ret_i at count=0 -> no change.
REQ-039 Write reg7=0x1234, then rst_i=1 with concurrent jal_i to reg7 -> reg7=0, count=0 next cycle.
